// File: rtl/mba_module_if.sv
// mba_if: operand/start/result bundle for the radix-4 Booth multiplier
// master drives start and operands; slave returns product, busy, done and pad output-enables
interface mba_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] io_oeb;
    modport master (output start, multiplicand, multiplier, input product, busy, done, io_oeb);
    modport slave  (input start, multiplicand, multiplier, output product, busy, done, io_oeb);
endinterface

// File: rtl/mba_module.sv
// mba_module: sequential radix-4 Modified Booth multiplier, WIDTH x WIDTH -> 2*WIDTH
// Ports: clock (rising edge), resetb (async active-low), bus (mba_if.slave: start,
// multiplicand, multiplier in; product, busy, done, io_oeb out).
// MBA_SIGNED_EN defined: two's complement operands, WIDTH/2 digits.
// MBA_SIGNED_EN undefined: unsigned operands zero-extended by two bits, WIDTH/2+1 digits.
module mba_module #(
    parameter int WIDTH = 8
) (
    input logic  clock,
    input logic  resetb,
    mba_if.slave bus
);
    localparam int PW = 2 * WIDTH;
`ifdef MBA_SIGNED_EN
    localparam int ND = WIDTH / 2;
    localparam int BW = WIDTH;
`else
    localparam int ND = WIDTH / 2 + 1;
    localparam int BW = WIDTH + 2;
`endif
    localparam int CW = $clog2(ND);
    typedef enum logic {IDLE, CALC} state_t;
    state_t        r_state, w_next;
    logic [PW-1:0] r_a, r_acc, r_product, w_pp, w_sum, w_a_ext;
    logic [BW:0]   r_b, w_b_ext;
    logic [CW-1:0] r_i;
    logic          r_done, w_last;
`ifdef MBA_SIGNED_EN
    assign w_a_ext = {{WIDTH{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
    assign w_b_ext = {bus.multiplier, 1'b0};
`else
    assign w_a_ext = {{WIDTH{1'b0}}, bus.multiplicand};
    assign w_b_ext = {2'b00, bus.multiplier, 1'b0};
`endif
    assign w_last = (r_state == CALC) && (r_i == CW'(ND - 1));
    // r_a is pre-shifted by 2i and r_b by 2i, so the current triplet is always r_b[2:0]
    always_comb begin
        w_pp = '0;
        case (r_b[2:0])
            3'b001, 3'b010: w_pp = r_a;
            3'b011:         w_pp = r_a << 1;
            3'b100:         w_pp = -(r_a << 1);
            3'b101, 3'b110: w_pp = -r_a;
            default:        w_pp = '0;
        endcase
        w_sum = r_acc + w_pp;
    end
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = bus.start ? CALC : IDLE;
            CALC:    w_next = w_last ? IDLE : CALC;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_i       <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if (r_state == IDLE && bus.start) begin
                r_a   <= w_a_ext;
                r_b   <= w_b_ext;
                r_acc <= '0;
                r_i   <= '0;
            end else if (r_state == CALC) begin
                r_acc <= w_sum;
                r_a   <= r_a << 2;
                r_b   <= r_b >> 2;
                r_i   <= r_i + CW'(1);
                if (w_last) begin
                    r_product <= w_sum;
                    r_done    <= 1'b1;
                end
            end
        end
    end
    assign bus.product = r_product;
    assign bus.busy    = (r_state == CALC);
    assign bus.done    = r_done;
    assign bus.io_oeb  = '0;
endmodule

// File: tb/tb_mba_module.sv
// tb_mba_module: directed self-checking bench for mba_module (WIDTH=8)
module tb_mba_module;
`ifdef MBA_SIGNED_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 5;
`endif
    logic clock;
    logic resetb;
    int   n_checks = 0;
    int   n_fail   = 0;
    mba_if #(.WIDTH(8)) bus ();
    mba_module #(.WIDTH(8)) dut (.clock(clock), .resetb(resetb), .bus(bus));
    initial clock = 1'b0;
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Starts an op at the current negedge; returns at the negedge after the done edge.
    // noise keeps start high with other operands during CALC to prove it is ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input bit noise, input string tag);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(posedge clock);
        @(negedge clock);
        bus.start        = noise;
        bus.multiplicand = ~a;
        bus.multiplier   = ~b;
        check({tag, " busy0"}, {15'd0, bus.busy}, 16'd1);
        check({tag, " done0"}, {15'd0, bus.done}, 16'd0);
        for (int j = 0; j < LAT - 1; j++) begin
            if (j == LAT - 2) bus.start = 1'b0;
            @(negedge clock);
            check({tag, " busy"}, {15'd0, bus.busy}, 16'd1);
            check({tag, " nodone"}, {15'd0, bus.done}, 16'd0);
        end
        bus.start = 1'b0;
        @(negedge clock);
        check({tag, " done"}, {15'd0, bus.done}, 16'd1);
        check({tag, " idle"}, {15'd0, bus.busy}, 16'd0);
        check({tag, " product"}, bus.product, exp);
    endtask
    task automatic after_op(input logic [15:0] exp, input string tag);
        @(negedge clock);
        check({tag, " pulse"}, {15'd0, bus.done}, 16'd0);
        check({tag, " norestart"}, {15'd0, bus.busy}, 16'd0);
        check({tag, " hold"}, bus.product, exp);
    endtask
    initial begin
        resetb           = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = 8'h00;
        bus.multiplier   = 8'h00;
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        repeat (5) @(negedge clock);
        check("reset product", bus.product, 16'h0000);
        check("reset busy", {15'd0, bus.busy}, 16'd0);
        check("reset done", {15'd0, bus.done}, 16'd0);
        check("io_oeb", bus.io_oeb, 16'h0000);
        run_op(8'h05, 8'h01, 16'h0005, 1'b0, "5x1");
        after_op(16'h0005, "5x1");
        run_op(8'h09, 8'h06, 16'h0036, 1'b0, "9x6");
        after_op(16'h0036, "9x6");
        run_op(8'h05, 8'h05, 16'h0019, 1'b0, "5x5");
        after_op(16'h0019, "5x5");
`ifdef MBA_SIGNED_EN
        run_op(8'hFD, 8'h07, 16'hFFEB, 1'b0, "m3x7");
        after_op(16'hFFEB, "m3x7");
        run_op(8'h80, 8'h80, 16'h4000, 1'b0, "80x80");
        after_op(16'h4000, "80x80");
`else
        run_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, "FFxFF");
        after_op(16'hFE01, "FFxFF");
`endif
        run_op(8'h03, 8'h04, 16'h000C, 1'b1, "ignore");
        after_op(16'h000C, "ignore");
        bus.start        = 1'b1;
        bus.multiplicand = 8'h07;
        bus.multiplier   = 8'h07;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        resetb = 1'b0;
        #1;
        check("abort product", bus.product, 16'h0000);
        check("abort busy", {15'd0, bus.busy}, 16'd0);
        check("abort done", {15'd0, bus.done}, 16'd0);
        @(negedge clock);
        resetb = 1'b1;
        for (int j = 0; j < LAT + 2; j++) begin
            @(negedge clock);
            check("abort nodone", {15'd0, bus.done}, 16'd0);
            check("abort hold", bus.product, 16'h0000);
        end
        run_op(8'h02, 8'h03, 16'h0006, 1'b0, "b2b first");
        run_op(8'h04, 8'h05, 16'h0014, 1'b0, "b2b second");
        after_op(16'h0014, "b2b second");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
